gpu_cmd_arbiter: RTL and testbench

//  Shares the single raster GPU command port between NUM_REQ requesters (CPU core, demo/sprite engines).

---
 rtl/gpu_cmd_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_gpu_cmd_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// gpu_cmd_arbiter
//
// Purpose:
//   Shares the single raster GPU command port between NUM_REQ requesters.
//   A round-robin arbiter pushes at most one accepted packet per cycle into
//   a DEPTH-entry command FIFO. An issue FSM pops the head entry, loads the
//   registered gpu_* outputs and fires a one-cycle gpu_execute_request pulse.
//   It then waits for the rasterizer to finish (gpu_busy low) before it
//   issues the next command.
//
// Ports:
//   clk                  in   clock
//   rst_async            in   synchronous active-high reset
//   req_valid[NUM_REQ]   in   requester i offers req_packet[i]
//   req_ready[NUM_REQ]   out  requester i accepted this cycle
//   req_packet[NUM_REQ]  in   {command, x0, y0, x1, y1, colour}, command in MSBs
//   gpu_command          out  registered raster command
//   gpu_x0/y0/x1/y1      out  registered coordinates (8 bits each)
//   gpu_colour           out  registered colour (3 bits)
//   gpu_execute_request  out  one-cycle start pulse
//   gpu_busy             in   rasterizer busy
//   fifo_count           out  number of queued entries
//   idle                 out  FIFO empty and FSM idle
// -----------------------------------------------------------------------------

package gpu_cmd_pkg;

    typedef enum logic [2:0] {
        RC_NOP   = 3'd0,
        RC_PIXEL = 3'd1,
        RC_LINE  = 3'd2,
        RC_RECT  = 3'd3,
        RC_FILL  = 3'd4,
        RC_CLEAR = 3'd5
    } raster_command_t;

    localparam int CMD_W = 3;
    localparam int PKT_W = CMD_W + 8 * 4 + 3;

endpackage

module gpu_cmd_arbiter
    import gpu_cmd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_async,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][PKT_W-1:0]     req_packet,
    output raster_command_t                   gpu_command,
    output logic [7:0]                        gpu_x0,
    output logic [7:0]                        gpu_y0,
    output logic [7:0]                        gpu_x1,
    output logic [7:0]                        gpu_y1,
    output logic [2:0]                        gpu_colour,
    output logic                              gpu_execute_request,
    input  logic                              gpu_busy,
    output logic [$clog2(DEPTH):0]            fifo_count,
    output logic                              idle
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [RR_W-1:0] LAST_REQ   = RR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    logic [PKT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [RR_W-1:0]  rr_ptr_r;
    state_t           state_r;
    state_t           state_next_s;

    logic             hi_found_s;
    logic [RR_W-1:0]  hi_idx_s;
    logic             lo_found_s;
    logic [RR_W-1:0]  lo_idx_s;
    logic             grant_found_s;
    logic [RR_W-1:0]  grant_idx_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;
    logic [PKT_W-1:0] head_s;

    assign fifo_full_s = (count_r == FULL_COUNT);
    assign fifo_count  = count_r;
    assign head_s      = mem_r[rd_ptr_r];
    assign idle        = (count_r == {CW{1'b0}}) && (state_r == ST_IDLE);

    // Round-robin search: the lowest valid index at or above rr_ptr wins;
    // otherwise the lowest valid index overall (the wrap-around case).
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = {RR_W{1'b0}};
        lo_found_s = 1'b0;
        lo_idx_s   = {RR_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            lo_found_s = lo_found_s | req_valid[i];
            lo_idx_s   = req_valid[i] ? RR_W'(i) : lo_idx_s;
            hi_found_s = hi_found_s | (req_valid[i] && (RR_W'(i) >= rr_ptr_r));
            hi_idx_s   = (req_valid[i] && (RR_W'(i) >= rr_ptr_r)) ? RR_W'(i) : hi_idx_s;
        end
        grant_found_s = hi_found_s | lo_found_s;
        grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // A full FIFO refuses every push, even in a cycle where the FSM pops.
    assign push_s = grant_found_s && !fifo_full_s && !rst_async;

    // One-hot ready for the granted requester only.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = push_s && (grant_idx_s == RR_W'(i));
        end
    end

    // FIFO storage; stale entries are harmless because count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= req_packet[grant_idx_s];
        end
    end

    // FIFO pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst_async) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            rr_ptr_r <= {RR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                rr_ptr_r <= (grant_idx_s == LAST_REQ) ? {RR_W{1'b0}} : grant_idx_s + RR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM next-state logic. The GPU gets one full cycle (GUARD) after
    // the pulse to raise busy before busy is trusted in WAIT.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != {CW{1'b0}}) && !gpu_busy) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_GUARD;
            ST_GUARD: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (!gpu_busy) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_async) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // GPU port registers: loaded on pop and held through GPU execution; the
    // pulse is high only in the cycle right after the pop (the ISSUE state).
    always_ff @(posedge clk) begin
        if (rst_async) begin
            gpu_command         <= RC_NOP;
            gpu_x0              <= 8'd0;
            gpu_y0              <= 8'd0;
            gpu_x1              <= 8'd0;
            gpu_y1              <= 8'd0;
            gpu_colour          <= 3'd0;
            gpu_execute_request <= 1'b0;
        end else begin
            gpu_execute_request <= pop_s;
            if (pop_s) begin
                gpu_command <= raster_command_t'(head_s[PKT_W-1 -: CMD_W]);
                gpu_x0      <= head_s[34:27];
                gpu_y0      <= head_s[26:19];
                gpu_x1      <= head_s[18:11];
                gpu_y1      <= head_s[10:3];
                gpu_colour  <= head_s[2:0];
            end
        end
    end

endmodule

// File: tb/tb_gpu_cmd_arbiter.sv
module tb_gpu_cmd_arbiter;
    import gpu_cmd_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DEPTH   = 4;

    logic                          clk;
    logic                          rst_async;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][PKT_W-1:0] req_packet;
    raster_command_t               gpu_command;
    logic [7:0]                    gpu_x0, gpu_y0, gpu_x1, gpu_y1;
    logic [2:0]                    gpu_colour;
    logic                          gpu_execute_request;
    logic                          gpu_busy;
    logic [$clog2(DEPTH):0]        fifo_count;
    logic                          idle;

    gpu_cmd_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_async           (rst_async),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_packet          (req_packet),
        .gpu_command         (gpu_command),
        .gpu_x0              (gpu_x0),
        .gpu_y0              (gpu_y0),
        .gpu_x1              (gpu_x1),
        .gpu_y1              (gpu_y1),
        .gpu_colour          (gpu_colour),
        .gpu_execute_request (gpu_execute_request),
        .gpu_busy            (gpu_busy),
        .fifo_count          (fifo_count),
        .idle                (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of packets plus the issue rules in cycle offsets.
    logic [PKT_W-1:0] q[$];
    int               rr;
    logic [PKT_W-1:0] last_pkt;
    logic             exp_pulse;
    logic             port_free;
    int               post;

    // GPU behaviour model used as stimulus.
    logic gpu_en;
    int   busy_len;
    int   busy_cnt;
    logic prev_pulse;
    int   cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [2:0] c, input logic [7:0] x0,
                                                input logic [7:0] y0, input logic [7:0] x1,
                                                input logic [7:0] y1, input logic [2:0] col);
        return {c, x0, y0, x1, y1, col};
    endfunction

    function automatic logic [PKT_W-1:0] rnd_pkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PKT_W-1:0];
    endfunction

    task automatic model_reset();
        q.delete();
        rr        = 0;
        last_pkt  = '0;
        exp_pulse = 1'b0;
        port_free = 1'b1;
        post      = 0;
    endtask

    // One clock cycle: check the DUT against the model at the falling edge,
    // advance the model with this cycle's inputs, then step past the rising edge.
    task automatic tick();
        int          g;
        int          idx;
        logic [1:0]  exp_ready;
        logic        pop;
        @(negedge clk);
        g = -1;
        if (!rst_async && q.size() < DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr + k) % NUM_REQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = 2'b00;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready",  64'(req_ready), 64'(exp_ready));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("pulse",      64'(gpu_execute_request), 64'(exp_pulse));
        chk("idle",       64'(idle), 64'(q.size() == 0 && port_free));
        chk("command",    64'(gpu_command), 64'(last_pkt[37:35]));
        chk("x0",         64'(gpu_x0), 64'(last_pkt[34:27]));
        chk("y0",         64'(gpu_y0), 64'(last_pkt[26:19]));
        chk("x1",         64'(gpu_x1), 64'(last_pkt[18:11]));
        chk("y1",         64'(gpu_y1), 64'(last_pkt[10:3]));
        chk("colour",     64'(gpu_colour), 64'(last_pkt[2:0]));
        chk("pulse_while_busy", 64'(gpu_execute_request && gpu_busy), 64'(0));
        prev_pulse = gpu_execute_request;

        if (rst_async) begin
            model_reset();
        end else begin
            pop       = port_free && q.size() != 0 && !gpu_busy;
            exp_pulse = pop;
            if (pop) begin
                last_pkt  = q.pop_front();
                port_free = 1'b0;
                post      = 1;
            end else if (!port_free) begin
                // busy is only trusted from the third cycle after the pop
                if (post >= 3 && !gpu_busy) port_free = 1'b1;
                else post++;
            end
            if (g >= 0) begin
                q.push_back(req_packet[g]);
                rr = (g + 1) % NUM_REQ;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (gpu_en) begin
            if (prev_pulse) busy_cnt = busy_len;
            if (busy_cnt > 0) begin
                gpu_busy = 1'b1;
                busy_cnt--;
            end else begin
                gpu_busy = 1'b0;
            end
        end
    endtask

    initial begin
        int pulses;
        cyc        = 0;
        gpu_en     = 1'b0;
        busy_len   = 0;
        busy_cnt   = 0;
        prev_pulse = 1'b0;
        gpu_busy   = 1'b0;
        rst_async  = 1'b1;
        req_valid  = 2'b11;
        req_packet[0] = rnd_pkt();
        req_packet[1] = rnd_pkt();
        model_reset();
        @(posedge clk);
        #1;

        // 1: reset held three cycles with all requesters valid
        for (int i = 0; i < 3; i++) tick();
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        rst_async = 1'b0;

        // 2: single RECT command from requester 0
        req_valid     = 2'b01;
        req_packet[0] = mk_pkt(3'(RC_RECT), 8'd10, 8'd90, 8'd204, 8'd130, 3'd6);
        tick();
        req_valid = 2'b00;
        chk("single_no_early_pulse", 64'(gpu_execute_request), 64'(0));
        tick();
        chk("single_pulse", 64'(gpu_execute_request), 64'(1));
        chk("single_cmd", 64'(gpu_command), 64'(RC_RECT));
        chk("single_x0", 64'(gpu_x0), 64'(10));
        chk("single_y0", 64'(gpu_y0), 64'(90));
        chk("single_x1", 64'(gpu_x1), 64'(204));
        chk("single_y1", 64'(gpu_y1), 64'(130));
        chk("single_col", 64'(gpu_colour), 64'(6));
        tick();
        chk("single_one_cycle_pulse", 64'(gpu_execute_request), 64'(0));
        tick();
        tick();
        chk("single_idle_T5", 64'(idle), 64'(1));

        // 3: both requesters valid continuously, FIFO draining
        req_valid = 2'b11;
        for (int i = 0; i < 16; i++) begin
            req_packet[0] = rnd_pkt();
            req_packet[1] = rnd_pkt();
            tick();
        end
        req_valid = 2'b00;
        for (int i = 0; i < 40 && !idle; i++) tick();
        chk("rr_drained", 64'(idle), 64'(1));

        // 4: GPU busy held, FIFO fills to DEPTH and blocks further pushes
        gpu_busy  = 1'b1;
        req_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
            req_packet[0] = rnd_pkt();
            tick();
        end
        chk("full_count", 64'(fifo_count), 64'(DEPTH));
        chk("full_ready", 64'(req_ready), 64'(0));
        chk("full_no_pulse", 64'(gpu_execute_request), 64'(0));
        req_valid = 2'b00;

        // 5: GPU raises busy the cycle after each pulse for 10 cycles
        gpu_en   = 1'b1;
        busy_len = 10;
        gpu_busy = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 80 && !(idle && pulses == DEPTH); i++) begin
            tick();
            if (gpu_execute_request) pulses++;
        end
        chk("busy_pulse_count", 64'(pulses), 64'(DEPTH));
        for (int i = 0; i < 20 && !idle; i++) tick();
        chk("busy_drained", 64'(idle), 64'(1));

        // 6: reset while three entries are queued and the FSM waits on busy
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            req_packet[0] = rnd_pkt();
            tick();
        end
        req_valid = 2'b00;
        tick();
        tick();
        chk("midop_count", 64'(fifo_count), 64'(3));
        rst_async = 1'b1;
        tick();
        rst_async = 1'b0;
        chk("midop_count_cleared", 64'(fifo_count), 64'(0));
        chk("midop_idle", 64'(idle), 64'(1));
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (gpu_execute_request) pulses++;
        end
        chk("midop_no_pulse", 64'(pulses), 64'(0));

        // Randomised traffic with random GPU busy lengths and rare resets
        for (int i = 0; i < 400; i++) begin
            req_valid     = 2'($urandom_range(0, 3));
            req_packet[0] = rnd_pkt();
            req_packet[1] = rnd_pkt();
            busy_len      = $urandom_range(0, 5);
            rst_async     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst_async = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 60 && !idle; i++) tick();
        chk("final_drained", 64'(idle), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
